// File: rtl/countdown_timer.sv
// Loadable down-counter with one-cycle expiry pulse and optional auto-reload.
// Control priority on every edge: abort, then start, then tick.
module countdown_timer #(
    parameter int WIDTH       = 4,
    parameter int AUTO_RELOAD = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] loadValue,
    input  logic             tick,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             expired
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_EXPIRED = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;
    logic [WIDTH-1:0] r_reload;
    logic [WIDTH-1:0] w_reload_nxt;
    logic             r_expired;
    logic             w_expired_nxt;

    // Next-state, counter and expiry-pulse decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = r_count;
        w_reload_nxt  = r_reload;
        w_expired_nxt = 1'b0;
        if (abort) begin
            w_state_nxt = S_IDLE;
            w_count_nxt = {WIDTH{1'b0}};
        end else if (start) begin
            w_reload_nxt = loadValue;
            if (loadValue != {WIDTH{1'b0}}) begin
                w_count_nxt = loadValue;
                w_state_nxt = S_RUN;
            end else begin
                w_count_nxt   = {WIDTH{1'b0}};
                w_state_nxt   = S_EXPIRED;
                w_expired_nxt = 1'b1;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_count_nxt = r_count;
                end
                S_RUN: begin
                    if (tick) begin
                        // count<=1 is the terminal step; guarding 0 too keeps it from wrapping
                        if (r_count > WIDTH'(1)) begin
                            w_count_nxt = r_count - WIDTH'(1);
                        end else begin
                            w_expired_nxt = 1'b1;
                            if (AUTO_RELOAD != 0) begin
                                w_count_nxt = r_reload;
                            end else begin
                                w_count_nxt = {WIDTH{1'b0}};
                                w_state_nxt = S_EXPIRED;
                            end
                        end
                    end else begin
                        w_count_nxt = r_count;
                    end
                end
                S_EXPIRED: begin
                    w_count_nxt = {WIDTH{1'b0}};
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_count_nxt = {WIDTH{1'b0}};
                end
            endcase
        end
    end

    // State, counter, reload and pulse registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_count   <= {WIDTH{1'b0}};
            r_reload  <= {WIDTH{1'b0}};
            r_expired <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_reload  <= w_reload_nxt;
            r_expired <= w_expired_nxt;
        end
    end

    assign count   = r_count;
    assign busy    = (r_state == S_RUN);
    assign done    = (r_state == S_EXPIRED);
    assign expired = r_expired;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer, one-shot and auto-reload instances.
module tb_countdown_timer;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] loadValue;
    logic       tick;
    logic       abort;
    logic [3:0] count;
    logic       busy;
    logic       done;
    logic       expired;
    logic [3:0] ar_count;
    logic       ar_busy;
    logic       ar_done;
    logic       ar_expired;

    int checks = 0;
    int errors = 0;

    countdown_timer #(.WIDTH(4), .AUTO_RELOAD(0)) dut (
        .clk(clk), .reset(reset), .start(start), .loadValue(loadValue),
        .tick(tick), .abort(abort), .count(count), .busy(busy),
        .done(done), .expired(expired)
    );

    countdown_timer #(.WIDTH(4), .AUTO_RELOAD(1)) dut_ar (
        .clk(clk), .reset(reset), .start(start), .loadValue(loadValue),
        .tick(tick), .abort(abort), .count(ar_count), .busy(ar_busy),
        .done(ar_done), .expired(ar_expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; loadValue = 4'd0; tick = 1'b0; abort = 1'b0;
        #2;
        checks++;
        if ({count, busy, done, expired} !== 7'b0000_000) begin
            errors++;
            $display("FAIL reset: count=%0d busy=%b done=%b expired=%b, want 0 0 0 0", count, busy, done, expired);
        end
        checks++;
        if ({ar_count, ar_busy, ar_done, ar_expired} !== 7'b0000_000) begin
            errors++;
            $display("FAIL reset_ar: count=%0d busy=%b done=%b expired=%b, want 0 0 0 0", ar_count, ar_busy, ar_done, ar_expired);
        end
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_reset_mid_count();
        start = 1'b1; loadValue = 4'd9; step();
        start = 1'b0; tick = 1'b1;
        for (int i = 0; i < 3; i++) step();
        tick = 1'b0;
        checks++;
        if (count !== 4'd6) begin
            errors++;
            $display("FAIL mid_pre: count=%0d, want 6", count);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({count, busy, done} !== 6'b0000_00) begin
            errors++;
            $display("FAIL mid_async: count=%0d busy=%b done=%b, want 0 0 0", count, busy, done);
        end
        #2 reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({count, busy, done, expired} !== 7'b0000_000) begin
                errors++;
                $display("FAIL mid_post%0d: count=%0d busy=%b done=%b expired=%b, want 0 0 0 0", i, count, busy, done, expired);
            end
        end
    endtask

    task automatic test_basic_countdown();
        logic [3:0] exp_c [5];
        exp_c = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
        start = 1'b1; loadValue = 4'd5; tick = 1'b0; step();
        start = 1'b0;
        checks++;
        if ({count, busy, done, expired} !== {4'd5, 3'b100}) begin
            errors++;
            $display("FAIL basic_load: count=%0d busy=%b done=%b expired=%b, want 5 1 0 0", count, busy, done, expired);
        end
        tick = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (count !== exp_c[i] || expired !== (i == 4) || busy !== (i != 4) || done !== (i == 4)) begin
                errors++;
                $display("FAIL basic_tick%0d: count=%0d expired=%b busy=%b done=%b, want %0d %b %b %b",
                         i, count, expired, busy, done, exp_c[i], (i == 4), (i != 4), (i == 4));
            end
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({count, busy, done, expired} !== {4'd0, 3'b010}) begin
                errors++;
                $display("FAIL basic_hold%0d: count=%0d busy=%b done=%b expired=%b, want 0 0 1 0", i, count, busy, done, expired);
            end
        end
        tick = 1'b0;
    endtask

    task automatic test_gapped_ticks();
        logic       pat   [6];
        logic [3:0] exp_c [6];
        pat   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        exp_c = '{4'd2, 4'd2, 4'd2, 4'd1, 4'd1, 4'd0};
        start = 1'b1; loadValue = 4'd3; step();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick = pat[i];
            step();
            checks++;
            if (count !== exp_c[i] || expired !== (i == 5)) begin
                errors++;
                $display("FAIL gapped%0d: count=%0d expired=%b, want %0d %b", i, count, expired, exp_c[i], (i == 5));
            end
        end
        tick = 1'b0;
    endtask

    task automatic test_auto_reload();
        logic [3:0] exp_c [6];
        exp_c = '{4'd1, 4'd2, 4'd1, 4'd2, 4'd1, 4'd2};
        start = 1'b1; loadValue = 4'd2; tick = 1'b0; step();
        start = 1'b0;
        checks++;
        if (ar_count !== 4'd2 || ar_busy !== 1'b1) begin
            errors++;
            $display("FAIL ar_load: count=%0d busy=%b, want 2 1", ar_count, ar_busy);
        end
        tick = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (ar_count !== exp_c[i] || ar_expired !== (i % 2 == 1) || ar_busy !== 1'b1 || ar_done !== 1'b0) begin
                errors++;
                $display("FAIL ar_tick%0d: count=%0d expired=%b busy=%b done=%b, want %0d %b 1 0",
                         i, ar_count, ar_expired, ar_busy, ar_done, exp_c[i], (i % 2 == 1));
            end
        end
        tick = 1'b0;
    endtask

    task automatic test_zero_and_full_scale();
        start = 1'b1; loadValue = 4'd0; step();
        start = 1'b0;
        checks++;
        if ({count, busy, done, expired} !== {4'd0, 3'b011}) begin
            errors++;
            $display("FAIL zero_load: count=%0d busy=%b done=%b expired=%b, want 0 0 1 1", count, busy, done, expired);
        end
        step();
        checks++;
        if ({done, expired} !== 2'b10) begin
            errors++;
            $display("FAIL zero_after: done=%b expired=%b, want 1 0", done, expired);
        end
        start = 1'b1; loadValue = 4'd15; step();
        start = 1'b0; tick = 1'b1;
        checks++;
        if (count !== 4'd15) begin
            errors++;
            $display("FAIL full_load: count=%0d, want 15", count);
        end
        for (int i = 0; i < 14; i++) step();
        checks++;
        if ({count, busy, expired} !== {4'd1, 2'b10}) begin
            errors++;
            $display("FAIL full_14: count=%0d busy=%b expired=%b, want 1 1 0", count, busy, expired);
        end
        step();
        checks++;
        if ({count, done, expired} !== {4'd0, 2'b11}) begin
            errors++;
            $display("FAIL full_15: count=%0d done=%b expired=%b, want 0 1 1", count, done, expired);
        end
        step();
        checks++;
        if ({count, expired} !== {4'd0, 1'b0}) begin
            errors++;
            $display("FAIL full_nowrap: count=%0d expired=%b, want 0 0", count, expired);
        end
    endtask

    task automatic test_simultaneous();
        // still EXPIRED from previous test, tick held high
        start = 1'b1; loadValue = 4'd4; tick = 1'b1; step();
        start = 1'b0; tick = 1'b0;
        checks++;
        if ({count, busy, done, expired} !== {4'd4, 3'b100}) begin
            errors++;
            $display("FAIL start_tick_exp: count=%0d busy=%b done=%b expired=%b, want 4 1 0 0", count, busy, done, expired);
        end
        start = 1'b1; loadValue = 4'd7; abort = 1'b1; step();
        start = 1'b0; abort = 1'b0;
        checks++;
        if ({count, busy, done, expired} !== {4'd0, 3'b000}) begin
            errors++;
            $display("FAIL abort_start: count=%0d busy=%b done=%b expired=%b, want 0 0 0 0", count, busy, done, expired);
        end
        tick = 1'b1; step();
        checks++;
        if ({count, busy} !== {4'd0, 1'b0}) begin
            errors++;
            $display("FAIL idle_tick: count=%0d busy=%b, want 0 0", count, busy);
        end
        start = 1'b1; loadValue = 4'd6; step();
        start = 1'b0; tick = 1'b0;
        checks++;
        if (count !== 4'd6) begin
            errors++;
            $display("FAIL start_tick_idle: count=%0d, want 6", count);
        end
        abort = 1'b1; tick = 1'b1; step();
        abort = 1'b0; tick = 1'b0;
        checks++;
        if ({count, busy, done, expired} !== {4'd0, 3'b000}) begin
            errors++;
            $display("FAIL abort_run: count=%0d busy=%b done=%b expired=%b, want 0 0 0 0", count, busy, done, expired);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_count();
        test_basic_countdown();
        test_gapped_ticks();
        test_auto_reload();
        test_zero_and_full_scale();
        test_simultaneous();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Synchronous loadable down-counter/timer; the counting-down counterpart of the team's ripple up-counter.
- Loads a start value, decrements once per qualified tick, and reports expiry.
- Used as the interval/timeout source feeding lab control logic; one counter register and a 3-state FSM, all in one clock domain.

Parameters:
WIDTH, 4, width of count, loadValue and internal reload register
AUTO_RELOAD, 0, 1 = on expiry reload the last loaded value and keep running; 0 = stop in EXPIRED

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  load loadValue and begin counting (sampled on clk edge)
loadValue  input  WIDTH  start value captured when start=1
tick  input  1  count-enable strobe; one decrement per cycle it is high in RUN
abort  input  1  return to IDLE from any state
count  output  WIDTH  current counter value (registered)
busy  output  1  high while state is RUN
done  output  1  high while state is EXPIRED (level)
expired  output  1  one-cycle pulse on each expiry (registered)

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (reset=0, immediate, independent of clk): state=IDLE, count=0, reload register=0, busy=0, done=0, expired=0. On deassertion, the FSM is in IDLE on the next edge.
- Reset mid-count discards the count. No expired pulse is produced.
- States:
  - IDLE: count held.
  - RUN: counting.
  - EXPIRED: count=0, done=1.
- busy and done are decoded from registered state. They are never both 1.
- Priority per edge: abort > start > tick.
- abort=1 (any state): state<=IDLE, count<=0, expired<=0.
- start=1, abort=0 (any state, including RUN and EXPIRED):
  - Reload register <= loadValue.
  - If loadValue!=0: count<=loadValue, state<=RUN, expired<=0.
  - If loadValue==0: count<=0, state<=EXPIRED, expired<=1 (zero-length timer expires immediately).
  - Any tick in the same cycle is ignored.
- RUN, tick=1, no start/abort:
  - count>1: count<=count-1.
  - count==1: expired<=1.
    - AUTO_RELOAD=0: count<=0, state<=EXPIRED.
    - AUTO_RELOAD=1: count<=reload register, stay RUN.
- RUN, tick=0: count held, expired<=0.
- EXPIRED: count held at 0. tick is ignored. Leave only via start or abort.
- IDLE: tick is ignored. count held.
- expired is high for exactly one cycle per expiry, even when tick is held high continuously.
- Latency: with loadValue=N>0 and tick continuously high from the cycle after start, expired and done (AUTO_RELOAD=0) rise at the Nth edge after the start edge.
- Arithmetic:
  - Unsigned, WIDTH bits.
  - count never decrements below 0 and never wraps to all-ones.
  - Maximum loadValue = 2^WIDTH-1.

Test Plan:
- Reset mid-count: start loadValue=9, 3 ticks (count=6), pull reset low between edges -> count=0, busy=0, done=0 immediately (before next edge); no expired pulse after release.
- Basic countdown, WIDTH=4: start loadValue=5, then tick=1 continuously -> count 5,4,3,2,1,0; expired=1 for one cycle at the 5th tick edge; done=1, busy=0 thereafter; count stays 0 with further ticks.
- Gapped ticks: loadValue=3, tick pattern 1,0,0,1,0,1 -> count 2,2,2,1,1,0; expiry only on the final tick.
- Auto-reload, AUTO_RELOAD=1: loadValue=2, tick held high for 6 cycles -> count 2,1,2,1,2,1,2; expired pulses at edges 2, 4, 6; busy stays 1; done stays 0.
- Zero load and full-scale load: start loadValue=0 -> EXPIRED, expired pulse on the same edge. start loadValue=15 with 15 ticks -> expiry, no wrap.
- Simultaneous events: start+tick together -> count=loadValue, not loadValue-1. abort+start together -> IDLE, count=0. start while EXPIRED with loadValue=4 -> RUN, count=4, done falls.
